// File: rtl/mux_bus_responder.sv
// 8088 multiplexed-bus slave: decodes a small window at BASE_ADDR, serves a byte
// store with a programmable number of wait states, and flags RD/WR collisions.
module mux_bus_responder #(
    parameter logic [15:0] BASE_ADDR   = 16'hFF00,
    parameter logic [15:0] ADDR_MASK   = 16'hFFF0,
    parameter bit          IS_IO       = 1'b1,
    parameter int          NUM_UNITS   = 16,
    parameter int          WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ALE,
    input  logic        IOM,
    input  logic        RD,
    input  logic        WR,
    input  logic [11:0] A,
    inout  wire  [7:0]  AD,
    output logic        READY,
    output logic        ERR
);
    localparam int          IDX_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [16:0] UNITS_LIM = 17'(NUM_UNITS);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_XFER, S_DONE} state_t;

    state_t      state_reg, state_next;
    logic [15:0] offset_reg;
    logic [3:0]  cnt_reg;
    logic        op_rd_reg;
    logic        err_reg;
    logic [7:0]  rdata_reg;
    logic [7:0]  mem_reg [NUM_UNITS] = '{default: 8'h00};

    logic [19:0]      bus_addr;
    logic [15:0]      bus_offset;
    logic [IDX_W-1:0] idx;
    logic             sel, one_low, both_low, in_range;
    logic             cycle_rd, xfer_entry, err_set, mem_we, ad_oe;

    assign bus_addr   = {A, AD};
    assign bus_offset = bus_addr[15:0] & ~ADDR_MASK;
    assign idx        = offset_reg[IDX_W-1:0];
    assign in_range   = ({1'b0, offset_reg} < UNITS_LIM);
    assign one_low    = RD ^ WR;
    assign both_low   = !RD && !WR;

    // Memory-space instances must also see the top nibble of the 20-bit address clear.
    assign sel = (IOM == IS_IO)
              && ((bus_addr[15:0] & ADDR_MASK) == BASE_ADDR)
              && (IS_IO || (bus_addr[19:16] == 4'h0));

    // In ADDR the direction comes straight off the strobes; afterwards from the latch.
    assign cycle_rd = (state_reg == S_ADDR) ? !RD : op_rd_reg;
    assign err_set  = (state_reg == S_ADDR) && both_low && !ALE;
    assign mem_we   = xfer_entry && !cycle_rd && in_range;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg  <= S_IDLE;
            offset_reg <= 16'h0000;
            cnt_reg    <= 4'd0;
            op_rd_reg  <= 1'b0;
            err_reg    <= 1'b0;
            rdata_reg  <= 8'h00;
        end else begin
            state_reg <= state_next;
            if (ALE) begin
                offset_reg <= bus_offset;
                op_rd_reg  <= 1'b0;
            end else if (state_reg == S_ADDR && one_low) begin
                op_rd_reg <= !RD;
            end
            if (state_reg == S_ADDR && state_next == S_WAIT) begin
                cnt_reg <= WAIT_LOAD;
            end else if (state_reg == S_WAIT && cnt_reg != 4'd0) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            if (err_set) begin
                err_reg <= 1'b1;
            end
            if (xfer_entry && cycle_rd) begin
                rdata_reg <= in_range ? mem_reg[idx] : 8'hFF;
            end
        end
    end

    // Storage sits outside the reset domain so its contents survive RESET.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_reg[idx] <= AD;
        end
    end

    always_comb begin
        state_next = state_reg;
        xfer_entry = 1'b0;
        case (state_reg)
            S_ADDR: begin
                if (one_low) begin
                    state_next = (WAIT_STATES == 0) ? S_XFER : S_WAIT;
                    xfer_entry = (WAIT_STATES == 0);
                end else if (both_low) begin
                    state_next = S_DONE;
                end
            end
            S_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = S_XFER;
                    xfer_entry = 1'b1;
                end
            end
            S_XFER: state_next = S_DONE;
            S_DONE: begin
                if (RD && WR) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = state_reg;
        endcase
        // A fresh address phase always wins, whatever was in flight.
        if (ALE) begin
            state_next = sel ? S_ADDR : S_IDLE;
            xfer_entry = 1'b0;
        end
    end

    always_comb begin
        READY = (state_reg != S_WAIT);
        ad_oe = ((state_reg == S_XFER) || (state_reg == S_DONE)) && op_rd_reg && !RD;
    end

    assign AD  = ad_oe ? rdata_reg : 8'hzz;
    assign ERR = err_reg;

endmodule

// File: tb/tb_mux_bus_responder.sv
// Bench for mux_bus_responder: a default instance and a zero-wait, 8-entry instance,
// driven by directed and random bus cycles and compared against a byte-array model.
module tb_mux_bus_responder;
    logic        clk = 1'b0;
    logic [1:0]  rst, ale, iom, rd, wr;
    logic [11:0] a [2];
    logic [7:0]  drv [2];
    logic [1:0]  drv_en;
    wire  [7:0]  ad0, ad1;
    wire  [1:0]  ready, err;

    int n_pass = 0;
    int n_total = 0;
    logic [7:0] model_mem [2][16];
    bit         model_err [2];

    always #5 clk = ~clk;

    assign ad0 = drv_en[0] ? drv[0] : 8'hzz;
    assign ad1 = drv_en[1] ? drv[1] : 8'hzz;

    // A released bus floats high, so "Z" reads back as 8'hFF.
    for (genvar gi = 0; gi < 8; gi++) begin : g_pull
        pullup (ad0[gi]);
        pullup (ad1[gi]);
    end

    mux_bus_responder dut0 (
        .CLK(clk), .RESET(rst[0]), .ALE(ale[0]), .IOM(iom[0]), .RD(rd[0]), .WR(wr[0]),
        .A(a[0]), .AD(ad0), .READY(ready[0]), .ERR(err[0])
    );

    mux_bus_responder #(.NUM_UNITS(8), .WAIT_STATES(0)) dut1 (
        .CLK(clk), .RESET(rst[1]), .ALE(ale[1]), .IOM(iom[1]), .RD(rd[1]), .WR(wr[1]),
        .A(a[1]), .AD(ad1), .READY(ready[1]), .ERR(err[1])
    );

    function automatic logic [7:0] ad_now(input int u);
        return (u == 0) ? ad0 : ad1;
    endfunction

    function automatic int ws_of(input int u);
        return (u == 0) ? 2 : 0;
    endfunction

    function automatic int units_of(input int u);
        return (u == 0) ? 16 : 8;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Address phase plus strobe; returns at the falling edge after the strobe was sampled.
    task automatic start_cycle(input int u, input bit io, input logic [19:0] addr,
                               input bit is_wr, input logic [7:0] wdata, input string tag);
        ale[u] = 1'b1;
        iom[u] = io;
        a[u] = addr[19:8];
        drv[u] = addr[7:0];
        drv_en[u] = 1'b1;
        @(negedge clk);
        check({tag, "/ale_ready"}, 32'(ready[u]), 32'd1);
        ale[u] = 1'b0;
        if (is_wr) begin
            drv[u] = wdata;
            wr[u] = 1'b0;
        end else begin
            drv_en[u] = 1'b0;
            rd[u] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic bus_cycle(input int u, input bit io, input logic [19:0] addr,
                             input bit is_wr, input logic [7:0] wdata, input string tag);
        bit hit;
        int off;
        int lows;
        logic [7:0] exp;
        hit = io && (addr[15:0] >= 16'hFF00) && (addr[15:0] <= 16'hFF0F);
        off = int'(addr[3:0]);
        exp = (hit && off < units_of(u)) ? model_mem[u][off] : 8'hFF;
        start_cycle(u, io, addr, is_wr, wdata, tag);
        lows = 0;
        while (ready[u] !== 1'b1 && lows < 40) begin
            lows++;
            @(negedge clk);
        end
        check({tag, "/ready_low"}, 32'(lows), hit ? 32'(ws_of(u)) : 32'd0);
        if (!is_wr) check({tag, "/rdata"}, 32'(ad_now(u)), 32'(exp));
        rd[u] = 1'b1;
        wr[u] = 1'b1;
        drv_en[u] = 1'b0;
        #1;
        check({tag, "/ad_released"}, 32'(ad_now(u)), 32'hFF);
        check({tag, "/err"}, 32'(err[u]), 32'(model_err[u]));
        if (is_wr && hit && off < units_of(u)) model_mem[u][off] = wdata;
        @(negedge clk);
    endtask

    initial begin
        logic [19:0] r_addr;
        rst = 2'b11; ale = 2'b00; iom = 2'b00; rd = 2'b11; wr = 2'b11; drv_en = 2'b00;
        a[0] = 12'h000; a[1] = 12'h000; drv[0] = 8'h00; drv[1] = 8'h00;
        for (int u = 0; u < 2; u++) begin
            model_err[u] = 1'b0;
            for (int i = 0; i < 16; i++) model_mem[u][i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d/rst_ready", u), 32'(ready[u]), 32'd1);
            check($sformatf("u%0d/rst_err", u), 32'(err[u]), 32'd0);
            check($sformatf("u%0d/rst_ad", u), 32'(ad_now(u)), 32'hFF);
        end
        rst = 2'b00;
        @(negedge clk);

        bus_cycle(0, 1'b1, 20'h0FF03, 1'b1, 8'hA5, "w_ff03");
        bus_cycle(0, 1'b1, 20'h0FF03, 1'b0, 8'h00, "r_ff03");
        bus_cycle(0, 1'b1, 20'h0FF13, 1'b0, 8'h00, "r_ff13_unsel");
        bus_cycle(0, 1'b0, 20'h0FF03, 1'b0, 8'h00, "mem_0ff03_unsel");

        // Reset lands in the middle of the wait states of a write.
        start_cycle(0, 1'b1, 20'h0FF03, 1'b1, 8'h3C, "w3c_rst");
        check("w3c_rst/in_wait", 32'(ready[0]), 32'd0);
        #2 rst[0] = 1'b1;
        #1 check("w3c_rst/ready_async", 32'(ready[0]), 32'd1);
        drv_en[0] = 1'b0;
        wr[0] = 1'b1;
        #1 check("w3c_rst/ad_async", 32'(ad0), 32'hFF);
        rst[0] = 1'b0;
        @(negedge clk);
        bus_cycle(0, 1'b1, 20'h0FF03, 1'b0, 8'h00, "r_ff03_after_rst");

        // Strobe collision, then ERR must hold until the next reset.
        bus_cycle(0, 1'b1, 20'h0FF01, 1'b1, 8'h5A, "w_ff01");
        ale[0] = 1'b1; iom[0] = 1'b1; a[0] = 12'h0FF; drv[0] = 8'h01; drv_en[0] = 1'b1;
        @(negedge clk);
        ale[0] = 1'b0; drv_en[0] = 1'b0; rd[0] = 1'b0; wr[0] = 1'b0;
        @(negedge clk);
        model_err[0] = 1'b1;
        check("collide/err", 32'(err[0]), 32'd1);
        check("collide/ready", 32'(ready[0]), 32'd1);
        check("collide/ad", 32'(ad0), 32'hFF);
        @(negedge clk);
        check("collide/ad_later", 32'(ad0), 32'hFF);
        rd[0] = 1'b1; wr[0] = 1'b1;
        @(negedge clk);
        bus_cycle(0, 1'b1, 20'h0FF01, 1'b0, 8'h00, "r_ff01_sticky");
        bus_cycle(0, 1'b1, 20'h0FF03, 1'b1, 8'hA5, "w_ff03_sticky");
        #2 rst[0] = 1'b1;
        #1 check("err_clear_rst", 32'(err[0]), 32'd0);
        model_err[0] = 1'b0;
        rst[0] = 1'b0;
        @(negedge clk);

        // New ALE on the last wait edge of a read, redirecting to an unselected address.
        start_cycle(0, 1'b1, 20'h0FF03, 1'b0, 8'h00, "abort_rd");
        @(negedge clk);
        check("abort_rd/still_wait", 32'(ready[0]), 32'd0);
        rd[0] = 1'b1;
        bus_cycle(0, 1'b1, 20'h0FF13, 1'b0, 8'h00, "abort_rd_new_ff13");

        // Same on a write: the aborted write must never reach storage.
        start_cycle(0, 1'b1, 20'h0FF04, 1'b1, 8'h77, "abort_wr");
        @(negedge clk);
        check("abort_wr/still_wait", 32'(ready[0]), 32'd0);
        wr[0] = 1'b1;
        bus_cycle(0, 1'b1, 20'h0FF05, 1'b0, 8'h00, "abort_wr_new_ff05");
        bus_cycle(0, 1'b1, 20'h0FF04, 1'b0, 8'h00, "r_ff04_untouched");

        // Zero-wait, 8-entry instance: out-of-range offsets read FF and drop writes.
        bus_cycle(1, 1'b1, 20'h0FF03, 1'b1, 8'h42, "u1_w_ff03");
        bus_cycle(1, 1'b1, 20'h0FF03, 1'b0, 8'h00, "u1_r_ff03");
        bus_cycle(1, 1'b1, 20'h0FF0A, 1'b0, 8'h00, "u1_r_ff0a");
        bus_cycle(1, 1'b1, 20'h0FF0A, 1'b1, 8'hEE, "u1_w_ff0a");
        for (int i = 0; i < 8; i++) begin
            bus_cycle(1, 1'b1, 20'h0FF00 + 20'(i), 1'b0, 8'h00, $sformatf("u1_scan%0d", i));
        end

        for (int t = 0; t < 60; t++) begin
            int u;
            bit io, w;
            u = int'($urandom_range(0, 1));
            io = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) != 0;
            r_addr[19:16] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            r_addr[15:8] = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hFF;
            r_addr[7:0] = 8'($urandom_range(0, 31));
            bus_cycle(u, io, r_addr, w, 8'($urandom), $sformatf("rnd%0d_u%0d", t, u));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
